// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO between instruction fetch and decode.
// Each entry holds an instruction plus its prediction metadata: PC,
// predicted next PC, GHR index, PHT state and redirect flag.
//
// Ports:
//   clk, globalReset (async, active-low)
//   fetch side : fetchValid, instrF, instrPCF, predictedPCF, GHRIndexF,
//                PHTStateF, redirectF -> fetchReady
//   decode side: decodeStall -> instrValid, instr, instrPC, predictedPC,
//                GHRIndex, PHTState, redirect
//   control    : flush (commit-time mispredict, single-cycle clear)
//   status     : count, full, empty
module fetch_queue #(
  parameter int WIDTH = 31,
  parameter int INDEX = 7,
  parameter int DEPTH = 4,
  parameter int PTR   = 1
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             fetchValid,
  input  logic [WIDTH:0]   instrF,
  input  logic [WIDTH:0]   instrPCF,
  input  logic [WIDTH:0]   predictedPCF,
  input  logic [INDEX:0]   GHRIndexF,
  input  logic [1:0]       PHTStateF,
  input  logic             redirectF,
  output logic             fetchReady,
  input  logic             decodeStall,
  input  logic             flush,
  output logic             instrValid,
  output logic [WIDTH:0]   instr,
  output logic [WIDTH:0]   instrPC,
  output logic [WIDTH:0]   predictedPC,
  output logic [INDEX:0]   GHRIndex,
  output logic [1:0]       PHTState,
  output logic             redirect,
  output logic [PTR+1:0]   count,
  output logic             full,
  output logic             empty
);

  typedef struct packed {
    logic [WIDTH:0] instr;
    logic [WIDTH:0] pc;
    logic [WIDTH:0] pred_pc;
    logic [INDEX:0] ghr_index;
    logic [1:0]     pht_state;
    logic           redirect;
  } entry_t;

  localparam logic [PTR+1:0] DEPTH_C = (PTR+2)'(DEPTH);
  localparam logic [WIDTH:0] NOP     = (WIDTH+1)'(32'h0000_0013);

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [PTR:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR+1:0] count_q, count_d;

  logic   push;
  logic   pop;
  entry_t head;

  // Status comes only from registered count, so fetchReady has no path
  // from decodeStall.
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign fetchReady = !full;
  assign instrValid = !empty;
  assign count      = count_q;

  assign push = fetchValid && fetchReady && !flush;
  assign pop  = instrValid && !decodeStall && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr:     instrF,
                            pc:        instrPCF,
                            pred_pc:   predictedPCF,
                            ghr_index: GHRIndexF,
                            pht_state: PHTStateF,
                            redirect:  redirectF};
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head read is combinational; an empty queue presents a NOP with no
  // redirect, the other fields are stale and qualified by instrValid.
  assign head        = mem_q[rd_ptr_q];
  assign instr       = empty ? NOP : head.instr;
  assign redirect    = !empty && head.redirect;
  assign instrPC     = head.pc;
  assign predictedPC = head.pred_pc;
  assign GHRIndex    = head.ghr_index;
  assign PHTState    = head.pht_state;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        globalReset;
  logic        fetchValid;
  logic [31:0] instrF, instrPCF, predictedPCF;
  logic [7:0]  GHRIndexF;
  logic [1:0]  PHTStateF;
  logic        redirectF;
  logic        fetchReady;
  logic        decodeStall;
  logic        flush;
  logic        instrValid;
  logic [31:0] instr, instrPC, predictedPC;
  logic [7:0]  GHRIndex;
  logic [1:0]  PHTState;
  logic        redirect;
  logic [2:0]  count;
  logic        full, empty;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pred;
    logic [7:0]  ghr;
    logic [1:0]  pht;
    logic        redir;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_queue #(.WIDTH(31), .INDEX(7), .DEPTH(4), .PTR(1)) dut (
    .clk(clk), .globalReset(globalReset), .fetchValid(fetchValid),
    .instrF(instrF), .instrPCF(instrPCF), .predictedPCF(predictedPCF),
    .GHRIndexF(GHRIndexF), .PHTStateF(PHTStateF), .redirectF(redirectF),
    .fetchReady(fetchReady), .decodeStall(decodeStall), .flush(flush),
    .instrValid(instrValid), .instr(instr), .instrPC(instrPC),
    .predictedPC(predictedPC), .GHRIndex(GHRIndex), .PHTState(PHTState),
    .redirect(redirect), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Scoreboard monitor: whenever decode consumes the head, it must match
  // the oldest entry the stimulus pushed.
  always @(negedge clk) begin
    if (globalReset === 1'b1 && instrValid && !decodeStall && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_pc", {32'h0, instrPC}, 64'hffff_ffff_ffff_ffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_instr", {32'h0, instr}, {32'h0, e.instr});
        check("pop_pc", {32'h0, instrPC}, {32'h0, e.pc});
        check("pop_meta", {predictedPC, GHRIndex, PHTState, redirect},
              {e.pred, e.ghr, e.pht, e.redir});
      end
    end
  end

  task automatic drive(input logic fv, input logic [31:0] i, input logic [31:0] pc,
                       input logic [31:0] pred, input logic [7:0] ghr,
                       input logic [1:0] pht, input logic rd);
    fetchValid   = fv;
    instrF       = i;
    instrPCF     = pc;
    predictedPCF = pred;
    GHRIndexF    = ghr;
    PHTStateF    = pht;
    redirectF    = rd;
  endtask

  // Record what the DUT should accept this cycle, then advance one edge.
  task automatic step();
    if (globalReset) begin
      if (flush) exp_q.delete();
      else if (fetchValid && fetchReady)
        exp_q.push_back('{instrF, instrPCF, predictedPCF, GHRIndexF, PHTStateF, redirectF});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_simple(input logic [31:0] i, input logic [31:0] pc);
    drive(1'b1, i, pc, pc + 32'd4, pc[9:2], 2'b01, 1'b0);
    step();
  endtask

  initial begin
    globalReset = 1'b0;
    decodeStall = 1'b1;
    flush       = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_instrValid", {63'h0, instrValid}, 64'h0);
    check("rst_count", {61'h0, count}, 64'h0);
    check("rst_full_empty_ready", {61'h0, full, empty, fetchReady}, 64'h3);
    check("rst_instr", {32'h0, instr}, 64'h13);
    check("rst_data", {instrPC, predictedPC}, 64'h0);
    check("rst_meta", {53'h0, GHRIndex, PHTState, redirect}, 64'h0);
    globalReset = 1'b1;

    // 1: three pushes while decode stalls; no same-cycle bypass.
    drive(1'b1, 32'h00500093, 32'h0, 32'h4, 8'h01, 2'b01, 1'b0);
    check("no_bypass", {63'h0, instrValid}, 64'h0);
    step();
    push_simple(32'h00a00113, 32'h4);
    push_simple(32'h002081b3, 32'h8);
    fetchValid = 1'b0;
    check("s1_count", {61'h0, count}, 64'd3);
    check("s1_valid", {63'h0, instrValid}, 64'h1);
    check("s1_head_instr", {32'h0, instr}, 64'h00500093);
    check("s1_head_pc", {32'h0, instrPC}, 64'h0);

    // 2: fill, reject push when full, then drain in order.
    push_simple(32'h00308233, 32'hC);
    check("s2_full_ready", {62'h0, full, fetchReady}, 64'h2);
    push_simple(32'h12345678, 32'h99);
    check("s2_count_full", {61'h0, count}, 64'd4);
    fetchValid  = 1'b0;
    decodeStall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("s2_drain_count", {61'h0, count}, 64'(3 - i));
      if (i == 0) check("s2_ready_after_pop", {63'h0, fetchReady}, 64'h1);
    end
    check("s2_empty", {63'h0, empty}, 64'h1);
    check("s2_nop", {32'h0, instr}, 64'h13);
    check("s2_sb_empty", 64'(exp_q.size()), 64'h0);

    // 3: steady push+pop from count=1, pointers wrap.
    push_simple(32'h00000100, 32'h100);
    check("s3_count_start", {61'h0, count}, 64'd1);
    for (int i = 1; i <= 10; i++) begin
      push_simple(32'h00000100 + 32'(i), 32'h100 + 32'(4 * i));
      check("s3_count_steady", {61'h0, count}, 64'd1);
    end
    fetchValid = 1'b0;
    step();
    check("s3_drained", {61'h0, count}, 64'd0);

    // 4: flush at count=3 drops the concurrent fetch entry.
    decodeStall = 1'b1;
    push_simple(32'h11111111, 32'h200);
    push_simple(32'h22222222, 32'h204);
    push_simple(32'h33333333, 32'h208);
    check("s4_count", {61'h0, count}, 64'd3);
    flush       = 1'b1;
    decodeStall = 1'b0;
    drive(1'b1, 32'hdeadbeef, 32'h40, 32'h44, 8'h10, 2'b10, 1'b0);
    step();
    flush      = 1'b0;
    fetchValid = 1'b0;
    check("s4_count_after", {61'h0, count}, 64'd0);
    check("s4_valid_ready", {62'h0, instrValid, fetchReady}, 64'h1);
    repeat (2) step();

    // 5: metadata travels with its instruction.
    decodeStall = 1'b1;
    drive(1'b1, 32'h00000063, 32'h300, 32'h100, 8'hA5, 2'b11, 1'b1);
    step();
    fetchValid = 1'b0;
    check("s5_pred", {32'h0, predictedPC}, 64'h100);
    check("s5_meta", {53'h0, GHRIndex, PHTState, redirect}, {53'h0, 8'hA5, 2'b11, 1'b1});
    decodeStall = 1'b0;
    step();
    check("s5_redirect_empty", {62'h0, redirect, empty}, 64'h1);

    // 6: asynchronous reset between edges.
    decodeStall = 1'b1;
    push_simple(32'h44444444, 32'h400);
    push_simple(32'h55555555, 32'h404);
    fetchValid = 1'b0;
    check("s6_count", {61'h0, count}, 64'd2);
    @(negedge clk);
    #2;
    globalReset = 1'b0;
    exp_q.delete();
    #1;
    check("s6_async_clear", {58'h0, instrValid, count, full, empty}, 64'h1);
    @(posedge clk);
    #2;
    globalReset = 1'b1;
    drive(1'b1, 32'h66666666, 32'h500, 32'h504, 8'h40, 2'b00, 1'b0);
    step();
    fetchValid = 1'b0;
    check("s6_head_after", {31'h0, instrValid, instrPC}, {31'h0, 1'b1, 32'h500});
    decodeStall = 1'b0;
    step();
    check("end_sb_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
